// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - request/response handshake bundle for the mul/div sequencer
interface muldiv_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequencer for the shared multicycle multiplier and unsigned divider
module muldiv_ctrl #(
  parameter int WIDTH    = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  muldiv_ctrl_if.slave       bus,
  output logic               err,
  output logic               mul_valid,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [WIDTH-1:0]   mul_c,
  output logic               div_valid,
  output logic [WIDTH-1:0]   div_a,
  output logic [WIDTH-1:0]   div_b,
  input  logic               div_done,
  input  logic [2*WIDTH-1:0] div_res
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, FIX, RESP} state_t;

  state_t            state, state_n;
  logic [3:0]        op_q;
  logic              sa_q, sb_q;
  logic [WIDTH-1:0]  opa, opb, res_q;
  logic [CW-1:0]     cnt;

  function automatic logic op_w(input logic [3:0] op);
    return (op == 4'd1) || (op >= 4'd6 && op <= 4'd9);
  endfunction

  function automatic logic op_rem(input logic [3:0] op);
    return (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic logic op_sgn(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd4) || (op == 4'd6) || (op == 4'd8);
  endfunction

  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
    return {{(WIDTH-32){x[31]}}, x};
  endfunction

  function automatic logic [WIDTH-1:0] zext32(input logic [31:0] x);
    return {{(WIDTH-32){1'b0}}, x};
  endfunction

  logic             accept, w_in, sgn_in, rem_in, mul_in, bad_in, bz, ovf, spec_hit;
  logic             sa_in, sb_in, fire, wd_hit, neg;
  logic [31:0]      a_lo, b_lo;
  logic [WIDTH-1:0] opa_n, opb_n, spec_res, fix_tmp, fix_res;

  assign bus.req_ready  = reset && (state == IDLE) && !flush;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = res_q;
  assign mul_valid      = (state == MUL_RUN);
  assign div_valid      = (state == DIV_RUN);
  assign mul_a          = opa;
  assign mul_b          = opb;
  assign div_a          = opa;
  assign div_b          = opb;
  assign accept         = bus.req_valid && bus.req_ready;
  assign wd_hit         = (cnt == CW'(MAX_WAIT - 1));

  // Decode the incoming op and resolve cases that never need a unit.
  always_comb begin
    a_lo     = bus.req_a[31:0];
    b_lo     = bus.req_b[31:0];
    w_in     = op_w(bus.req_op);
    sgn_in   = op_sgn(bus.req_op);
    rem_in   = op_rem(bus.req_op);
    mul_in   = (bus.req_op < 4'd2);
    bad_in   = (bus.req_op > 4'd9);
    sa_in    = w_in ? bus.req_a[31] : bus.req_a[WIDTH-1];
    sb_in    = w_in ? bus.req_b[31] : bus.req_b[WIDTH-1];
    bz       = w_in ? (b_lo == 32'd0) : (bus.req_b == '0);
    ovf      = sgn_in && (w_in ? (a_lo == 32'h8000_0000 && b_lo == 32'hFFFF_FFFF)
                               : (bus.req_a == MIN_NEG && bus.req_b == '1));
    spec_hit = bad_in || (!mul_in && (bz || ovf));
    opa_n    = bus.req_a;
    opb_n    = bus.req_b;
    case (bus.req_op)
      4'd2, 4'd4: begin
        opa_n = bus.req_a[WIDTH-1] ? ('0 - bus.req_a) : bus.req_a;
        opb_n = bus.req_b[WIDTH-1] ? ('0 - bus.req_b) : bus.req_b;
      end
      4'd6, 4'd8: begin
        opa_n = zext32(a_lo[31] ? (32'd0 - a_lo) : a_lo);
        opb_n = zext32(b_lo[31] ? (32'd0 - b_lo) : b_lo);
      end
      4'd7, 4'd9: begin
        opa_n = zext32(a_lo);
        opb_n = zext32(b_lo);
      end
      default: ;
    endcase
    spec_res = '0;
    if (!bad_in && bz)
      spec_res = rem_in ? (w_in ? sext32(a_lo) : bus.req_a) : '1;
    else if (!bad_in && ovf)
      spec_res = rem_in ? '0 : (w_in ? sext32(a_lo) : bus.req_a);
  end

  always_comb begin
    neg     = op_sgn(op_q) && (op_rem(op_q) ? sa_q : (sa_q ^ sb_q));
    fix_tmp = neg ? ('0 - res_q) : res_q;
    fix_res = op_w(op_q) ? sext32(fix_tmp[31:0]) : fix_tmp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    fire    = 1'b0;
    case (state)
      IDLE:    if (accept) state_n = spec_hit ? RESP : (mul_in ? MUL_RUN : DIV_RUN);
      MUL_RUN: if (mul_done) state_n = FIX;
               else if (wd_hit) begin state_n = RESP; fire = 1'b1; end
      DIV_RUN: if (div_done) state_n = FIX;
               else if (wd_hit) begin state_n = RESP; fire = 1'b1; end
      FIX:     state_n = RESP;
      RESP:    if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      fire    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res_q <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      err <= fire;
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.req_op;
          sa_q  <= sa_in;
          sb_q  <= sb_in;
          opa   <= opa_n;
          opb   <= opb_n;
          cnt   <= '0;
          res_q <= spec_res;
        end
        MUL_RUN, DIV_RUN: begin
          cnt <= cnt + 1'b1;
          if (state == MUL_RUN && mul_done)
            res_q <= mul_c;
          else if (state == DIV_RUN && div_done)
            res_q <= op_rem(op_q) ? div_res[2*WIDTH-1:WIDTH] : div_res[WIDTH-1:0];
          else if (fire)
            res_q <= '0;
        end
        FIX:     res_q <= fix_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with behavioural unit stubs
module tb_muldiv_ctrl;
  localparam logic [3:0] OP_MUL = 4'd0, OP_MULW = 4'd1, OP_DIV = 4'd2, OP_DIVU = 4'd3,
                         OP_REM = 4'd4, OP_REMU = 4'd5, OP_REMW = 4'd8;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic err, mul_valid, mul_done, div_valid, div_done;
  logic [63:0] mul_a, mul_b, mul_c, div_a, div_b;
  logic [127:0] div_res;

  muldiv_ctrl_if #(.WIDTH(64)) bus ();

  muldiv_ctrl #(.WIDTH(64), .MAX_WAIT(255)) dut (
    .clk(clk), .reset(rst_n), .flush(flush), .bus(bus.slave), .err(err),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c),
    .div_valid(div_valid), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_res(div_res)
  );

  always #5 clk = ~clk;

  int mul_lat = 0, div_lat = 0, mcnt = 0, dcnt = 0, div_cyc = 0;
  bit hang = 1'b0;
  always @(posedge clk) begin
    mcnt <= mul_valid ? mcnt + 1 : 0;
    dcnt <= div_valid ? dcnt + 1 : 0;
    if (div_valid) div_cyc <= div_cyc + 1;
  end
  assign mul_done = mul_valid && !hang && (mcnt == mul_lat);
  assign div_done = div_valid && !hang && (dcnt == div_lat);
  assign mul_c    = mul_a * mul_b;
  assign div_res  = (div_b == 64'd0) ? 128'd0 : {div_a % div_b, div_a / div_b};

  int total = 0, bad = 0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    case (op)
      4'd0: return a * b;
      4'd1: return sx(a32 * b32);
      4'd2: return (b == 0) ? '1 : (a == MINV && b == '1) ? a : 64'(sa / sb);
      4'd3: return (b == 0) ? '1 : a / b;
      4'd4: return (b == 0) ? a : (a == MINV && b == '1) ? 64'd0 : 64'(sa % sb);
      4'd5: return (b == 0) ? a : a % b;
      4'd6: return (b32 == 0) ? '1 : (a32 == 32'h8000_0000 && b32 == '1) ? sx(a32) : sx(32'(sa32 / sb32));
      4'd7: return (b32 == 0) ? '1 : sx(a32 / b32);
      4'd8: return (b32 == 0) ? sx(a32) : (a32 == 32'h8000_0000 && b32 == '1) ? 64'd0 : sx(32'(sa32 % sb32));
      4'd9: return (b32 == 0) ? sx(a32) : sx(a32 % b32);
      default: return 64'd0;
    endcase
  endfunction

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input bit push);
    int n;
    n = 0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    #1;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout op=%0d req_ready=%0b want 1", op, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (push) exp_q.push_back(ref_model(op, a, b));
  endtask

  task automatic get_resp(input string name);
    int n;
    logic [63:0] e;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 600);
    total++;
    if (!bus.resp_valid) begin
      bad++;
      $display("FAIL %s resp_timeout resp_valid=%0b want 1", name, bus.resp_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    if (bus.resp_data !== e) begin
      bad++;
      $display("FAIL %s resp_data got %h want %h", name, bus.resp_data, e);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.resp_valid, mul_valid, div_valid, err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got %b want 00000", {bus.req_ready, bus.resp_valid, mul_valid, div_valid, err});
    end
    total++;
    if (bus.resp_data !== 64'd0) begin bad++; $display("FAIL reset_data got %h want 0", bus.resp_data); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_div_signed();
    send(OP_DIV, -64'sd7, 64'd2, 1'b1);
    @(negedge clk);
    total++;
    if ({div_valid, div_a, div_b} !== {1'b1, 64'd7, 64'd2}) begin
      bad++; $display("FAIL div_operands got v=%b a=%h b=%h want v=1 a=7 b=2", div_valid, div_a, div_b);
    end
    get_resp("div_neg");
    send(OP_REM, -64'sd7, 64'd2, 1'b1);
    get_resp("rem_neg");
  endtask

  task automatic test_special(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input string name);
    int c0;
    c0 = div_cyc;
    send(op, a, b, 1'b1);
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL %s early_resp got %b want 1", name, bus.resp_valid); end
    get_resp(name);
    total++;
    if (div_cyc != c0) begin bad++; $display("FAIL %s div_engaged got %0d cycles want 0", name, div_cyc - c0); end
  endtask

  task automatic test_word();
    send(OP_REMW, 64'hFFFF_FFFF_8000_0001, 64'd3, 1'b1);
    @(negedge clk);
    total++;
    if ({div_valid, div_a} !== {1'b1, 64'h7FFF_FFFF}) begin
      bad++; $display("FAIL remw_operand got v=%b a=%h want v=1 a=7fffffff", div_valid, div_a);
    end
    get_resp("remw");
    send(OP_MULW, 64'h7FFF_FFFF, 64'd2, 1'b1);
    get_resp("mulw");
  endtask

  task automatic test_mul_stall();
    int n;
    logic [63:0] d0, e;
    mul_lat = 4;
    send(OP_MUL, 64'd123456789, 64'd1000, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 50);
    total++;
    if (n != 7) begin bad++; $display("FAIL mul_latency got %0d want 7", n); end
    d0 = bus.resp_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.resp_valid, bus.req_ready, bus.resp_data} !== {2'b10, d0}) begin
        bad++; $display("FAIL stall_hold got v=%b rdy=%b d=%h want v=1 rdy=0 d=%h",
                        bus.resp_valid, bus.req_ready, bus.resp_data, d0);
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if ({bus.resp_valid, bus.req_ready, bus.resp_data} !== {2'b10, e}) begin
      bad++; $display("FAIL stall_data got v=%b rdy=%b d=%h want v=1 rdy=0 d=%h",
                      bus.resp_valid, bus.req_ready, bus.resp_data, e);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    total++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      bad++; $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", bus.resp_valid, bus.req_ready);
    end
    mul_lat = 0;
  endtask

  task automatic test_flush();
    int seen;
    div_lat = 10;
    send(OP_DIVU, 64'd100, 64'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    total++;
    if ({div_valid, bus.resp_valid, bus.req_ready} !== 3'b000) begin
      bad++; $display("FAIL flush_drop got dv=%b rv=%b rdy=%b want 000", div_valid, bus.resp_valid, bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_op = OP_MUL; bus.req_a = 64'd9; bus.req_b = 64'd9;
    @(negedge clk);
    total++;
    if (mul_valid !== 1'b0) begin bad++; $display("FAIL flush_override mul_valid got %b want 0", mul_valid); end
    bus.req_valid = 1'b0;
    flush = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (bus.resp_valid) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_noresp got %0d resp cycles want 0", seen); end
    div_lat = 0;
    send(OP_MUL, 64'hDEAD_BEEF, 64'h1234_5678, 1'b1);
    get_resp("mul_after_flush");
  endtask

  task automatic test_reset_midrun();
    div_lat = 30;
    send(OP_DIV, 64'd1000, 64'd3, 1'b0);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.resp_valid, mul_valid, div_valid, err, div_a, div_b, bus.resp_data} !== '0) begin
      bad++; $display("FAIL async_reset got rdy=%b rv=%b mv=%b dv=%b err=%b da=%h db=%h d=%h want all 0",
                      bus.req_ready, bus.resp_valid, mul_valid, div_valid, err, div_a, div_b, bus.resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    div_lat = 0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_recover got %b want 1", bus.req_ready); end
  endtask

  task automatic test_watchdog();
    int errs, n;
    hang = 1'b1;
    send(OP_MUL, 64'd3, 64'd4, 1'b0);
    exp_q.push_back(64'd0);
    errs = 0; n = 0;
    do begin @(negedge clk); n++; if (err) errs++; end while (!bus.resp_valid && n < 400);
    total++;
    if ({errs, mul_valid} !== {32'd1, 1'b0}) begin
      bad++; $display("FAIL watchdog got err_pulses=%0d mul_valid=%b want 1 0", errs, mul_valid);
    end
    hang = 1'b0;
    get_resp("watchdog_data");
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      4: return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      mul_lat = $urandom_range(0, 3);
      div_lat = $urandom_range(0, 3);
      send(op, pick(), pick(), 1'b1);
      get_resp("random_op");
    end
    mul_lat = 0; div_lat = 0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
    test_reset();
    test_div_signed();
    test_special(OP_DIVU, 64'd5, 64'd0, "divu_zero");
    test_special(OP_REMU, 64'd5, 64'd0, "remu_zero");
    test_special(OP_DIV, MINV, '1, "div_ovf");
    test_special(OP_REM, MINV, '1, "rem_ovf");
    test_special(4'd12, 64'd5, 64'd3, "unused_op");
    test_word();
    test_mul_stall();
    test_flush();
    test_reset_midrun();
    test_watchdog();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
